// File: rtl/vm_request_arbiter.sv
// vm_request_arbiter: synchronises three raw buttons and latches one pending
// request per source. A four-state controller issues one request at a time
// to the vending FSM. It checks credit before issuing, waits for a
// per-source acknowledge (or times out), then holds a fixed idle gap.
module vm_request_arbiter #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_coin,
  input  logic       btn_coffee,
  input  logic       btn_sprite,
  input  logic [1:0] vm_credit,
  input  logic       vm_coffee_done,
  input  logic       vm_sprite_done,
  output logic       o_coin,
  output logic       o_coffee,
  output logic       o_sprite,
  output logic       o_busy,
  output logic       o_reject,
  output logic       o_err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  // Source vectors are ordered {sprite, coffee, coin}.
  logic [2:0] btn_raw_s;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0] warm_q, warm_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] rise_s, clr_s, sel_s;
  logic       ready_s, pass_s, ack_s;
  state_t     state_q, state_d;
  logic [2:0] src_q, src_d;
  logic [1:0] credit_q, credit_d;
  logic [3:0] cnt_q, cnt_d;
  logic       reject_q, reject_d;
  logic       err_q, err_d;

  assign btn_raw_s = {btn_sprite, btn_coffee, btn_coin};

  // Synchroniser, edge history and pending bits.
  // Edge detection stays masked for three edges after reset so that a
  // button already held at release is absorbed into the history.
  always_comb begin
    sync1_d = btn_raw_s;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    ready_s = (warm_q == 2'd3);
    if (ready_s) begin
      warm_d = warm_q;
      rise_s = sync2_q & ~hist_q;
    end else begin
      warm_d = warm_q + 2'd1;
      rise_s = 3'b000;
    end
    // A new edge wins over a clear on the same edge.
    pend_d = (pend_q & ~clr_s) | rise_s;
  end

  // Next-state logic: selection, credit check, acknowledge wait and gap timing.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    err_d    = err_q;
    clr_s    = 3'b000;
    sel_s    = 3'b000;
    pass_s   = 1'b0;
    ack_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 3'b000) begin
          if (pend_q[2]) begin
            sel_s = 3'b100;
          end else if (pend_q[1]) begin
            sel_s = 3'b010;
          end else begin
            sel_s = 3'b001;
          end
          clr_s  = sel_s;
          pass_s = (sel_s[2] & (vm_credit == 2'd3)) |
                   (sel_s[1] & (vm_credit != 2'd0)) |
                   (sel_s[0] & (vm_credit != 2'd3));
          if (pass_s) begin
            state_d  = ST_ISSUE;
            src_d    = sel_s;
            credit_d = vm_credit;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 4'd0;
      end
      ST_WAIT: begin
        // Coin has no done strobe; a change of credit is its acknowledge.
        ack_s = (src_q[2] & vm_sprite_done) |
                (src_q[1] & vm_coffee_done) |
                (src_q[0] & (vm_credit != credit_q));
        if (ack_s) begin
          state_d = ST_GAP;
          cnt_d   = 4'd0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_GAP;
          cnt_d   = 4'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      hist_q   <= 3'b000;
      warm_q   <= 2'd0;
      pend_q   <= 3'b000;
      state_q  <= ST_IDLE;
      src_q    <= 3'b000;
      credit_q <= 2'd0;
      cnt_q    <= 4'd0;
      reject_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      warm_q   <= warm_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      src_q    <= src_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    o_coin        = (state_q == ST_ISSUE) & src_q[0];
    o_coffee      = (state_q == ST_ISSUE) & src_q[1];
    o_sprite      = (state_q == ST_ISSUE) & src_q[2];
    o_busy        = (state_q != ST_IDLE);
    o_reject      = reject_q;
    o_err_timeout = err_q;
  end

endmodule
